// File: rtl/lsu_pkg.sv
// Shared opcode constants, FSM state encoding and access-size decode for the load/store unit.
package lsu_pkg;

  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LD  = 6'd58;
  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STD = 6'd62;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  // Access size in bytes; 0 marks an opcode this unit does not execute.
  function automatic logic [3:0] op_size(input logic [5:0] op);
    case (op)
      OP_LBZ, OP_STB: op_size = 4'd1;
      OP_LHZ, OP_STH: op_size = 4'd2;
      OP_LWZ, OP_STW: op_size = 4'd4;
      OP_LD,  OP_STD: op_size = 4'd8;
      default:        op_size = 4'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    op_is_store = (op == OP_STB) || (op == OP_STH) || (op == OP_STW) || (op == OP_STD);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational size masking: zero-extends store data and load data from the access size.
module lsu_align (
  input  logic [3:0]  st_size,
  input  logic [63:0] st_in,
  output logic [63:0] st_out,
  input  logic [3:0]  ld_size,
  input  logic [63:0] ld_in,
  output logic [63:0] ld_out
);

  function automatic logic [63:0] zext(input logic [3:0] size, input logic [63:0] d);
    case (size)
      4'd1:    zext = {56'd0, d[7:0]};
      4'd2:    zext = {48'd0, d[15:0]};
      4'd4:    zext = {32'd0, d[31:0]};
      default: zext = d;
    endcase
  endfunction

  assign st_out = zext(st_size, st_in);
  assign ld_out = zext(ld_size, ld_in);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with memory timeout; define LSU_MISALIGN_TRAP_EN
// to fault misaligned accesses instead of forwarding them to memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [63:0] req_base,
  input  logic [15:0] req_disp,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [5:0]  mem_opcode,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        fault
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [4:0]    rd_q;

  logic [3:0]  acc_size;
  logic        acc_store;
  logic        acc_ok;
  logic        misalign;
  logic [15:0] disp_eff;
  logic [63:0] ea;
  logic [63:0] st_data;
  logic [63:0] ld_data;

  assign acc_size  = op_size(req_opcode);
  assign acc_store = op_is_store(req_opcode);
  // Doubleword forms are DS-form: the low two displacement bits are opcode extension, not offset.
  assign disp_eff  = (req_opcode == OP_LD || req_opcode == OP_STD) ? {req_disp[15:2], 2'b00} : req_disp;
  assign ea        = req_base + {{48{disp_eff[15]}}, disp_eff};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = |(ea[2:0] & (acc_size[2:0] - 3'd1));
`else
  assign misalign = 1'b0;
`endif

  assign acc_ok = (acc_size != 4'd0) && !misalign;

  lsu_align u_align (
    .st_size (acc_size),
    .st_in   (req_wdata),
    .st_out  (st_data),
    .ld_size (op_size(mem_opcode)),
    .ld_in   (mem_rdata),
    .ld_out  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      rd_q       <= '0;
      req_ready  <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_opcode <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      fault      <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (acc_ok) begin
              state      <= MEM;
              req_ready  <= 1'b0;
              tmo_cnt    <= '0;
              rd_q       <= req_rd;
              mem_addr   <= ea;
              mem_wdata  <= st_data;
              mem_opcode <= req_opcode;
              mem_read   <= !acc_store;
              mem_write  <= acc_store;
            end else begin
              fault <= 1'b1;
            end
          end
        end
        MEM: begin
          // An ack on the final counted cycle completes normally rather than timing out.
          if (mem_ack) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_write) begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end else begin
              state    <= RESP;
              wb_valid <= 1'b1;
              wb_data  <= ld_data;
              wb_rd    <= rd_q;
            end
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            fault     <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level reference model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [63:0] req_base;
  logic [15:0] req_disp;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [5:0]  mem_opcode;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_base(req_base), .req_disp(req_disp), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_opcode(mem_opcode),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [5:0] op);
    case (op)
      6'd34, 6'd38: return 1;
      6'd40, 6'd44: return 2;
      6'd32, 6'd36: return 4;
      6'd58, 6'd62: return 8;
      default:      return 0;
    endcase
  endfunction

  // One request end to end; ack_at = index of the MEM cycle carrying mem_ack (>= TMO means never).
  task automatic txn(input logic [5:0] op, input logic [63:0] base, input logic [15:0] disp,
                     input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata,
                     input int ack_at, input int stall);
    int                 sz;
    bit                 st;
    bit                 trap;
    logic signed [15:0] d;
    logic [63:0]        ea;
    logic [63:0]        mask;
    sz   = size_of(op);
    st   = (op == 6'd38 || op == 6'd44 || op == 6'd36 || op == 6'd62);
    d    = disp;
    if (sz == 8) d[1:0] = 2'b00;
    ea   = base + 64'(d);
    mask = (sz == 8) ? {64{1'b1}} : ((64'd1 << (8 * sz)) - 64'd1);
    trap = (sz == 0);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz != 0 && (ea % 64'(sz)) != 64'd0) trap = 1'b1;
`endif

    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_opcode = op; req_base = base; req_disp = disp;
    req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_opcode = 6'($urandom); req_base = {$urandom, $urandom};
    req_disp = 16'($urandom); req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);

    if (trap) begin
      chk("trap_fault", fault, 1);
      chk("trap_read", mem_read, 0);
      chk("trap_write", mem_write, 0);
      chk("trap_ready", req_ready, 1);
      @(negedge clk);
      chk("trap_pulse", fault, 0);
      return;
    end

    for (int k = 0; k < TMO; k++) begin
      chk("mem_read", mem_read, !st);
      chk("mem_write", mem_write, st);
      chk("mem_addr", mem_addr, ea);
      chk("mem_opcode", mem_opcode, op);
      if (st) chk("mem_wdata", mem_wdata, wdata & mask);
      chk("mem_busy", req_ready, 0);
      chk("mem_wb", wb_valid, 0);
      chk("mem_fault", fault, 0);
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      mem_ack = 1'b0;
      if (k == ack_at) break;
      if (k == TMO - 1) begin
        chk("tmo_fault", fault, 1);
        chk("tmo_read", mem_read, 0);
        chk("tmo_write", mem_write, 0);
        chk("tmo_ready", req_ready, 1);
        chk("tmo_wb", wb_valid, 0);
        @(negedge clk);
        chk("tmo_pulse", fault, 0);
        return;
      end
    end

    if (st) begin
      chk("st_no_wb", wb_valid, 0);
      chk("st_ready", req_ready, 1);
      chk("st_write_drop", mem_write, 0);
      chk("st_fault", fault, 0);
    end else begin
      chk("ld_read_drop", mem_read, 0);
      for (int s = 0; s <= stall; s++) begin
        chk("wb_valid", wb_valid, 1);
        chk("wb_data", wb_data, rdata & mask);
        chk("wb_rd", wb_rd, rd);
        chk("wb_busy", req_ready, 0);
        wb_ready = (s == stall);
        @(negedge clk);
        wb_ready = 1'b0;
      end
      chk("wb_done", wb_valid, 0);
      chk("wb_idle", req_ready, 1);
      chk("wb_fault", fault, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_read"}, mem_read, 0);
    chk({tag, "_write"}, mem_write, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_opcode"}, mem_opcode, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
  endtask

  logic [5:0] ops [10] = '{6'd34, 6'd40, 6'd32, 6'd58, 6'd38, 6'd44, 6'd36, 6'd62, 6'd0, 6'd50};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_base = '0; req_disp = '0;
    req_wdata = '0; req_rd = '0; mem_rdata = '0; mem_ack = 1'b0; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    txn(6'd34, 64'h10, 16'hFFFC, 64'h0, 5'd3, 64'hFFFF_FFFF_FFFF_FFAB, 0, 0);
    txn(6'd44, 64'h20, 16'd6, 64'h1234_5678, 5'd0, 64'h0, 2, 0);
    txn(6'd58, 64'h100, 16'd0, 64'h0, 5'd7, 64'h0, 99, 0);
    txn(6'd58, 64'h200, 16'd9, 64'h0, 5'd9, 64'h0123_4567_89AB_CDEF, 1, 3);
    txn(6'd62, 64'h300, 16'hFFF7, 64'hCAFE_BABE_DEAD_BEEF, 5'd0, 64'h0, 3, 0);
    txn(6'd32, 64'h6, 16'd0, 64'h0, 5'd4, 64'hDEAD_BEEF_CAFE_F00D, 0, 0);
    txn(6'd1, 64'h40, 16'd0, 64'h0, 5'd1, 64'h0, 0, 0);

    // Stray ack while idle must not disturb anything.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ready", req_ready, 1);
    chk("stray_wb", wb_valid, 0);
    chk("stray_fault", fault, 0);

    // Reset while a load is waiting in MEM.
    req_valid = 1'b1; req_opcode = 6'd58; req_base = 64'h800; req_disp = 16'd0; req_rd = 5'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_read", mem_read, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fault", fault, 0);
    chk("post_rst_wb", wb_valid, 0);
    txn(6'd40, 64'h1000, 16'd2, 64'h0, 5'd12, 64'hAAAA_BBBB_CCCC_1357, 0, 1);

    repeat (60) begin
      txn(ops[$urandom_range(0, 9)], {$urandom, $urandom}, 16'($urandom), {$urandom, $urandom},
          5'($urandom), {$urandom, $urandom}, $urandom_range(0, 5), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
